// File: rtl/myip_led_axil_slave.sv
// AXI4-Lite slave exposing four 32-bit registers (LED value, control, blink period, scratch)
// and an LED driver that can blink the LED value with a programmable period.
module myip_led_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int LED_WIDTH          = 8
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [LED_WIDTH-1:0]              led_out
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;

    // Write-path state
    logic            aw_held_reg;
    logic [1:0]      aw_idx_reg;
    logic            w_held_reg;
    logic [DW-1:0]   w_data_reg;
    logic [NB-1:0]   w_strb_reg;
    logic            bvalid_reg;

    // Read-path state
    logic            rvalid_reg;
    logic [DW-1:0]   rdata_reg;

    // Register file: 0 LED_VAL, 1 CTRL, 2 BLINK_PERIOD, 3 SCRATCH
    logic [DW-1:0]   regs_reg [4];

    // Blink state
    logic [DW-1:0]        blink_cnt_reg;
    logic                 phase_reg;
    logic [LED_WIDTH-1:0] led_reg;

    logic            aw_hs;
    logic            w_hs;
    logic            ar_hs;
    logic            commit;
    logic [1:0]      commit_idx;
    logic [DW-1:0]   commit_data;
    logic [NB-1:0]   commit_strb;
    logic [4*NB-1:0] byte_we;
    logic            blink_active;
    logic [DW-1:0]   blink_period;

    assign s00_axi_awready = !aw_held_reg && !bvalid_reg;
    assign s00_axi_wready  = !w_held_reg && !bvalid_reg;
    assign s00_axi_arready = !rvalid_reg;

    assign aw_hs = s00_axi_awvalid && s00_axi_awready;
    assign w_hs  = s00_axi_wvalid && s00_axi_wready;
    assign ar_hs = s00_axi_arvalid && s00_axi_arready;

    // A write commits once address and data are each either held or handshaking now.
    assign commit      = (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
    assign commit_idx  = aw_held_reg ? aw_idx_reg : s00_axi_awaddr[3:2];
    assign commit_data = w_held_reg ? w_data_reg : s00_axi_wdata;
    assign commit_strb = w_held_reg ? w_strb_reg : s00_axi_wstrb;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_reg_we
            for (gj = 0; gj < NB; gj++) begin : g_byte_we
                assign byte_we[gi*NB+gj] = commit && (commit_idx == 2'(gi)) && commit_strb[gj];
            end
        end
    endgenerate

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < 4; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < NB; j++) begin
                    if (byte_we[i*NB+j]) begin
                        regs_reg[i][8*j +: 8] <= commit_data[8*j +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            aw_held_reg <= 1'b0;
            aw_idx_reg  <= '0;
            w_held_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
        end else begin
            if (bvalid_reg && s00_axi_bready) begin
                bvalid_reg <= 1'b0;
            end
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
            end else begin
                if (aw_hs) begin
                    aw_held_reg <= 1'b1;
                    aw_idx_reg  <= s00_axi_awaddr[3:2];
                end
                if (w_hs) begin
                    w_held_reg <= 1'b1;
                    w_data_reg <= s00_axi_wdata;
                    w_strb_reg <= s00_axi_wstrb;
                end
            end
        end
    end

    // Reads sample the register file before any same-edge write lands.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= regs_reg[s00_axi_araddr[3:2]];
        end else if (rvalid_reg && s00_axi_rready) begin
            rvalid_reg <= 1'b0;
        end
    end

    assign blink_period = regs_reg[2];
    assign blink_active = regs_reg[1][0] && (blink_period != '0);

    // The >= compare makes a period shortened below the current count wrap immediately.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            led_reg       <= '0;
        end else begin
            if (!blink_active) begin
                blink_cnt_reg <= '0;
                phase_reg     <= 1'b0;
            end else if (blink_cnt_reg >= blink_period - 1'b1) begin
                blink_cnt_reg <= '0;
                phase_reg     <= !phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
            led_reg <= phase_reg ? '0 : regs_reg[0][LED_WIDTH-1:0];
        end
    end

    assign s00_axi_bvalid = bvalid_reg;
    assign s00_axi_bresp  = 2'b00;
    assign s00_axi_rvalid = rvalid_reg;
    assign s00_axi_rdata  = rdata_reg;
    assign s00_axi_rresp  = 2'b00;
    assign led_out        = led_reg;

    logic unused_ok;
    assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

endmodule
